// File: rtl/spi_slave_xcvr_if.sv
// Host-side byte interface of the SPI slave transceiver: one-deep transmit
// holding register handshake, receive strobe and frame status pulses.
interface spi_slave_xcvr_if;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic       tx_underrun;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_end;
    logic       rx_abort;

    modport slave (
        input  tx_data, tx_load,
        output tx_ready, tx_underrun, rx_data, rx_valid, busy, frame_end, rx_abort
    );

    modport master (
        output tx_data, tx_load,
        input  tx_ready, tx_underrun, rx_data, rx_valid, busy, frame_end, rx_abort
    );
endinterface

// File: rtl/spi_slave_xcvr.sv
// SPI mode-3 slave: oversamples SCK/NSS/MOSI in sys_clk, receives MSB-first,
// and shifts the host-supplied holding byte out on MISO.
//
// state   | meaning
// S_IDLE  | NSS high, waiting for a slave-select falling edge
// S_LOAD  | one cycle: move holding register into the transmit shifter
// S_SHIFT | frame active: sample on SCK rise, shift MISO on SCK fall
module spi_slave_xcvr #(
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_nrst,
    input  logic              SCK,
    input  logic              NSS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    spi_slave_xcvr_if.slave   host
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, nss_sync, mosi_sync;
    logic                   sck_d, nss_d;
    logic                   sck_rise, sck_fall, nss_fall;
    logic                   sck_s, nss_s, mosi_s;

    state_t     state;
    logic [7:0] hold;
    logic [7:0] tx_shift;
    logic [7:0] tx_nxt;
    logic [6:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       reload;
    logic       load_acc;

    logic       tx_ready_q, tx_underrun_q, rx_valid_q, frame_end_q, rx_abort_q;
    logic [7:0] rx_data_q;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign nss_s  = nss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Edge pulses are registered so every FSM action sees a full-cycle strobe.
    always_ff @(posedge sys_clk) begin
        if (!sys_nrst) begin
            sck_sync  <= '1;
            nss_sync  <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b1;
            nss_d     <= 1'b1;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            nss_fall  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], NSS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_d     <= sck_s;
            nss_d     <= nss_s;
            sck_rise  <= sck_s & ~sck_d;
            sck_fall  <= ~sck_s & sck_d;
            nss_fall  <= ~nss_s & nss_d;
        end
    end

    assign load_acc = host.tx_load & tx_ready_q;

    // Next transmit shifter value; MISO is registered from it so the pin
    // follows the shifter without an extra cycle of delay.
    always_comb begin
        reload = 1'b0;
        tx_nxt = tx_shift;
        if (!nss_s) begin
            if (state == S_LOAD)
                reload = 1'b1;
            else if (state == S_SHIFT && sck_rise && bit_cnt == 3'd7)
                reload = 1'b1;

            if (reload)
                tx_nxt = tx_ready_q ? 8'h00 : hold;
            else if (state == S_SHIFT && sck_fall && bit_cnt != 3'd0)
                tx_nxt = {tx_shift[6:0], 1'b0};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_nrst) begin
            state         <= S_IDLE;
            hold          <= 8'h00;
            tx_ready_q    <= 1'b1;
            tx_shift      <= 8'h00;
            rx_shift      <= 7'h00;
            bit_cnt       <= 3'd0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_end_q   <= 1'b0;
            rx_abort_q    <= 1'b0;
            MISO          <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_end_q   <= 1'b0;
            rx_abort_q    <= 1'b0;
            tx_shift      <= tx_nxt;
            MISO          <= tx_nxt[7];

            if (reload) begin
                if (tx_ready_q)
                    tx_underrun_q <= 1'b1;
                else
                    tx_ready_q <= 1'b1;
            end
            // A load coinciding with a reload wins: the reload already took
            // the old holding value above.
            if (load_acc) begin
                hold       <= host.tx_data;
                tx_ready_q <= 1'b0;
            end

            if (nss_s) begin
                if (state != S_IDLE) begin
                    frame_end_q <= 1'b1;
                    rx_abort_q  <= (bit_cnt != 3'd0);
                end
                state   <= S_IDLE;
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    S_IDLE:  if (nss_fall) state <= S_LOAD;
                    S_LOAD:  state <= S_SHIFT;
                    S_SHIFT: begin
                        if (sck_rise) begin
                            rx_shift <= {rx_shift[5:0], mosi_s};
                            if (bit_cnt == 3'd7) begin
                                rx_data_q  <= {rx_shift, mosi_s};
                                rx_valid_q <= 1'b1;
                                bit_cnt    <= 3'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign MISO_oe          = ~nss_s;
    assign host.busy        = ~nss_s;
    assign host.tx_ready    = tx_ready_q;
    assign host.tx_underrun = tx_underrun_q;
    assign host.rx_data     = rx_data_q;
    assign host.rx_valid    = rx_valid_q;
    assign host.frame_end   = frame_end_q;
    assign host.rx_abort    = rx_abort_q;

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Bench for spi_slave_xcvr: plays an SPI mode-3 master against the DUT and
// checks it against a byte-level model of the holding register and receiver.
module tb_spi_slave_xcvr;
    localparam int SYNC = 2;
    localparam int H    = 6;

    logic sys_clk  = 1'b0;
    logic sys_nrst = 1'b0;
    logic SCK      = 1'b1;
    logic NSS      = 1'b1;
    logic MOSI     = 1'b0;
    logic MISO, MISO_oe;

    spi_slave_xcvr_if host ();

    spi_slave_xcvr #(.SYNC_STAGES(SYNC)) dut (
        .sys_clk  (sys_clk),
        .sys_nrst (sys_nrst),
        .SCK      (SCK),
        .NSS      (NSS),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .MISO_oe  (MISO_oe),
        .host     (host)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-level model: holding register, expected receive stream, pulse tallies.
    bit         m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    logic [7:0] m_cur  = 8'h00;
    logic [7:0] m_rx_last = 8'h00;
    logic [7:0] exp_rx_q[$];
    int         exp_cyc_q[$];
    int m_under = 0, m_fend = 0, m_abort = 0;
    int o_under = 0, o_fend = 0, o_abort = 0;
    bit chk_en = 1'b0;

    function automatic logic [7:0] model_take();
        if (m_full) begin
            m_full = 1'b0;
            return m_hold;
        end
        m_under++;
        return 8'h00;
    endfunction

    always @(negedge sys_clk) begin
        if (chk_en) begin
            if (host.rx_valid) begin
                chk("rx_pending", 32'(exp_rx_q.size() > 0), 32'd1);
                if (exp_rx_q.size() > 0) begin
                    m_rx_last = exp_rx_q.pop_front();
                    chk("rx_data", 32'(host.rx_data), 32'(m_rx_last));
                    chk("rx_valid_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end else begin
                chk("rx_data_held", 32'(host.rx_data), 32'(m_rx_last));
            end
            chk("oe_vs_busy", 32'(MISO_oe), 32'(host.busy));
            o_under += int'(host.tx_underrun);
            o_fend  += int'(host.frame_end);
            o_abort += int'(host.rx_abort);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic waitc(input int n);
        repeat (n) tick();
    endtask

    task automatic load_tx(input logic [7:0] d);
        chk("tx_ready_at_load", 32'(host.tx_ready), 32'(!m_full));
        host.tx_data = d;
        host.tx_load = 1'b1;
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = d;
        end
        tick();
        host.tx_load = 1'b0;
    endtask

    task automatic frame_start();
        NSS   = 1'b0;
        m_cur = model_take();
        waitc(8);
        chk("busy_in_frame", 32'(host.busy), 32'd1);
        chk("tx_ready_after_load", 32'(host.tx_ready), 32'(!m_full));
    endtask

    // Sends the top nbits of mo; optional mid-byte load, optional load timed
    // to land on the byte-boundary reload cycle. Returns the MISO bits seen.
    task automatic send_bits(input logic [7:0] mo, input int nbits,
                             input bit do_ld, input logic [7:0] ld,
                             input bit collide, input logic [7:0] cd,
                             output logic [7:0] mb);
        logic [7:0] cur;
        logic [7:0] mask;
        bit         acc;
        cur  = m_cur;
        mask = 8'hFF << (8 - nbits);
        mb   = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            SCK  = 1'b0;
            MOSI = mo[i];
            for (int j = 1; j <= H; j++) begin
                tick();
                if (do_ld && i == 4 && j == 2) begin
                    chk("tx_ready_at_load", 32'(host.tx_ready), 32'(!m_full));
                    host.tx_data = ld;
                    host.tx_load = 1'b1;
                    if (!m_full) begin
                        m_full = 1'b1;
                        m_hold = ld;
                    end
                end else begin
                    host.tx_load = 1'b0;
                end
            end
            mb[i] = MISO;
            SCK   = 1'b1;
            if (i == 0) begin
                exp_rx_q.push_back(mo);
                exp_cyc_q.push_back(cyc + SYNC + 2);
                acc   = !m_full;
                m_cur = model_take();
                if (collide && acc) begin
                    m_full = 1'b1;
                    m_hold = cd;
                end
            end
            for (int j = 1; j <= H; j++) begin
                tick();
                if (collide && i == 0 && j == SYNC + 1) begin
                    host.tx_data = cd;
                    host.tx_load = 1'b1;
                end else begin
                    host.tx_load = 1'b0;
                end
            end
            if (i == 0)
                chk("tx_ready_after_byte", 32'(host.tx_ready), 32'(!m_full));
        end
        chk("miso_bits", 32'(mb & mask), 32'(cur & mask));
    endtask

    task automatic frame_stop(input bit partial);
        NSS = 1'b1;
        m_fend++;
        if (partial) m_abort++;
        waitc(10);
        chk("busy_idle", 32'(host.busy), 32'd0);
        chk("miso_oe_idle", 32'(MISO_oe), 32'd0);
        chk("frame_end_count", 32'(o_fend), 32'(m_fend));
        chk("rx_abort_count", 32'(o_abort), 32'(m_abort));
        chk("underrun_count", 32'(o_under), 32'(m_under));
        chk("rx_all_seen", 32'(exp_rx_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals();
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_miso_oe", 32'(MISO_oe), 32'd0);
        chk("rst_tx_ready", 32'(host.tx_ready), 32'd1);
        chk("rst_tx_underrun", 32'(host.tx_underrun), 32'd0);
        chk("rst_rx_data", 32'(host.rx_data), 32'h00);
        chk("rst_rx_valid", 32'(host.rx_valid), 32'd0);
        chk("rst_busy", 32'(host.busy), 32'd0);
        chk("rst_frame_end", 32'(host.frame_end), 32'd0);
        chk("rst_rx_abort", 32'(host.rx_abort), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mb0, mb1, mb2;
        host.tx_data = 8'h00;
        host.tx_load = 1'b0;
        waitc(3);
        check_reset_vals();
        sys_nrst = 1'b1;
        tick();
        chk_en = 1'b1;
        waitc(4);

        // single byte
        load_tx(8'hA5);
        frame_start();
        send_bits(8'h3C, 8, 1'b0, 8'h00, 1'b0, 8'h00, mb0);
        frame_stop(1'b0);
        chk("lit_single_miso", 32'(mb0), 32'hA5);
        chk("lit_single_rx", 32'(host.rx_data), 32'h3C);
        chk("lit_single_ready", 32'(host.tx_ready), 32'd1);

        // back-to-back, holding refilled in time for every boundary
        load_tx(8'h11);
        frame_start();
        send_bits(8'h01, 8, 1'b1, 8'h22, 1'b0, 8'h00, mb0);
        send_bits(8'h80, 8, 1'b1, 8'h33, 1'b0, 8'h00, mb1);
        send_bits(8'hFF, 8, 1'b1, 8'h44, 1'b0, 8'h00, mb2);
        frame_stop(1'b0);
        chk("lit_b2b_miso0", 32'(mb0), 32'h11);
        chk("lit_b2b_miso1", 32'(mb1), 32'h22);
        chk("lit_b2b_miso2", 32'(mb2), 32'h33);
        chk("lit_b2b_under", 32'(o_under), 32'd1);

        // underrun: nothing loaded
        frame_start();
        send_bits(8'hC6, 8, 1'b0, 8'h00, 1'b0, 8'h00, mb0);
        frame_stop(1'b0);
        chk("lit_under_miso", 32'(mb0), 32'h00);
        chk("lit_under_count", 32'(o_under), 32'd3);

        // abort after 5 bits; second load while full is ignored
        load_tx(8'h77);
        load_tx(8'h99);
        frame_start();
        send_bits(8'hE7, 5, 1'b1, 8'h88, 1'b0, 8'h00, mb0);
        frame_stop(1'b1);
        chk("lit_abort_miso", 32'(mb0), 32'h70);
        chk("lit_abort_rx_kept", 32'(host.rx_data), 32'hC6);
        chk("lit_abort_hold_kept", 32'(host.tx_ready), 32'd0);
        frame_start();
        send_bits(8'h5E, 8, 1'b0, 8'h00, 1'b0, 8'h00, mb0);
        frame_stop(1'b0);
        chk("lit_after_abort_miso", 32'(mb0), 32'h88);
        chk("lit_after_abort_rx", 32'(host.rx_data), 32'h5E);

        // load collides with the byte-boundary reload
        load_tx(8'h5A);
        frame_start();
        send_bits(8'hAA, 8, 1'b0, 8'h00, 1'b1, 8'hC3, mb0);
        chk("lit_collide_ready", 32'(host.tx_ready), 32'd0);
        send_bits(8'h55, 8, 1'b0, 8'h00, 1'b0, 8'h00, mb1);
        send_bits(8'h3C, 8, 1'b0, 8'h00, 1'b0, 8'h00, mb2);
        frame_stop(1'b0);
        chk("lit_collide_miso0", 32'(mb0), 32'h5A);
        chk("lit_collide_miso1", 32'(mb1), 32'h00);
        chk("lit_collide_miso2", 32'(mb2), 32'hC3);

        // reset in the middle of a byte
        load_tx(8'h12);
        frame_start();
        send_bits(8'hF0, 4, 1'b0, 8'h00, 1'b0, 8'h00, mb0);
        sys_nrst = 1'b0;
        chk_en   = 1'b0;
        NSS      = 1'b1;
        SCK      = 1'b1;
        MOSI     = 1'b0;
        tick();
        check_reset_vals();
        m_full    = 1'b0;
        m_rx_last = 8'h00;
        exp_rx_q.delete();
        exp_cyc_q.delete();
        waitc(2);
        sys_nrst = 1'b1;
        tick();
        chk_en = 1'b1;
        waitc(4);
        load_tx(8'h6D);
        frame_start();
        send_bits(8'h9B, 8, 1'b0, 8'h00, 1'b0, 8'h00, mb0);
        frame_stop(1'b0);
        chk("lit_post_reset_miso", 32'(mb0), 32'h6D);
        chk("lit_post_reset_rx", 32'(host.rx_data), 32'h9B);
        chk("lit_total_under", 32'(o_under), 32'd7);
        chk("lit_total_fend", 32'(o_fend), 32'd7);
        chk("lit_total_abort", 32'(o_abort), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
